issue_scoreboard: RTL and testbench

//  Issue controller for the in-order IF/ID/EX/MEM/WB pipeline. Sits between decode (ID) and the ds->ex

---
 rtl/issue_scoreboard_pkg.sv | 11 +
 rtl/issue_scoreboard_sb_counter.sv | 44 ++++
 rtl/issue_scoreboard.sv | 99 +++++++++
 tb/tb_issue_scoreboard.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared constants for the ID-stage issue scoreboard: register-file geometry and counter width.
// The x0 index is never tracked, because writes to it are architecturally discarded.
package issue_scoreboard_pkg;

   localparam int NREG     = 32;
   localparam int RA_W     = 5;
   localparam int SB_CNT_W = 2;

   localparam logic [RA_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/issue_scoreboard_sb_counter.sv
// Pending-write counter for one architectural register. It saturates at both ends,
// and an inc together with a dec in the same cycle leaves the count unchanged.
module sb_counter
   import issue_scoreboard_pkg::*;
#(
   parameter int CNT_W = SB_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (inc && !dec && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_ONE;
      end else if (dec && !inc && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_ONE;
      end
   end

   assign cnt  = r_cnt;
   assign busy = (r_cnt != '0);

`ifndef SYNTHESIS
   // A writeback with nothing pending means the pipeline lost track of an instruction.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(dec && (r_cnt == '0)))
            else $error("sb_counter: writeback with no pending write");
      end
   end
`endif

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: holds ID on RAW hazards and on counter saturation until writeback.
// Optional hazard-stall statistics are enabled by the SB_STATS_EN macro.
module issue_scoreboard
   import issue_scoreboard_pkg::*;
#(
   parameter int NREG_P = NREG,
   parameter int RA_W_P = RA_W,
   parameter int CNT_W  = SB_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ds_valid,
   input  logic [RA_W_P-1:0] ds_rs1,
   input  logic              ds_rs1_en,
   input  logic [RA_W_P-1:0] ds_rs2,
   input  logic              ds_rs2_en,
   input  logic [RA_W_P-1:0] ds_rd,
   input  logic              ds_we,
   input  logic              ex_allow_in,
   input  logic              flush,
   input  logic              wb_valid,
   input  logic              wb_we,
   input  logic [RA_W_P-1:0] wb_rd,
   output logic              ds_ready_go,
   output logic              ds_fire,
   output logic [NREG_P-1:0] busy_vec,
   output logic [31:0]       stall_cnt
);

   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [RA_W_P-1:0] ZERO_IDX = RA_W_P'(ZERO_REG);

   logic [NREG_P-1:0]            w_busy;
   logic [NREG_P-1:0][CNT_W-1:0] w_cnt;

   logic w_inc;
   logic w_dec;
   logic w_rs1_hz;
   logic w_rs2_hz;
   logic w_rd_sat;
   logic w_hazard;

   // x0 has no counter; it always reads as idle.
   assign w_busy[0] = 1'b0;
   assign w_cnt[0]  = '0;

   assign w_inc = ds_fire && ds_we && (ds_rd != ZERO_IDX);
   assign w_dec = wb_valid && wb_we && (wb_rd != ZERO_IDX);

   genvar gi;
   generate
      for (gi = 1; gi < NREG_P; gi = gi + 1) begin : g_reg
         logic w_inc_hit;
         logic w_dec_hit;

         assign w_inc_hit = w_inc && (ds_rd == RA_W_P'(gi));
         assign w_dec_hit = w_dec && (wb_rd == RA_W_P'(gi));

         sb_counter #(
            .CNT_W (CNT_W)
         ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (w_inc_hit),
            .dec   (w_dec_hit),
            .cnt   (w_cnt[gi]),
            .busy  (w_busy[gi])
         );
      end
   endgenerate

   // Hazards are judged from registered counts only; a same-cycle writeback is not bypassed.
   assign w_rs1_hz = ds_rs1_en && (ds_rs1 != ZERO_IDX) && w_busy[ds_rs1];
   assign w_rs2_hz = ds_rs2_en && (ds_rs2 != ZERO_IDX) && w_busy[ds_rs2];
   assign w_rd_sat = ds_we && (ds_rd != ZERO_IDX) && (w_cnt[ds_rd] == CNT_MAX);
   assign w_hazard = w_rs1_hz || w_rs2_hz || w_rd_sat;

   assign ds_ready_go = !w_hazard && !flush;
   assign ds_fire     = ds_valid && ds_ready_go && ex_allow_in;
   assign busy_vec    = w_busy;

`ifdef SB_STATS_EN
   logic [31:0] r_stall_cnt;

   // Only hazard stalls are counted; back-pressure from EX alone is not the scoreboard's doing.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (ds_valid && !flush && w_hazard && ex_allow_in) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed and randomized checks of issue_scoreboard against a model built from a queue of
// in-flight writers; pending counts are derived by counting queue entries per register.
module tb_issue_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        ds_valid;
   logic [4:0]  ds_rs1;
   logic        ds_rs1_en;
   logic [4:0]  ds_rs2;
   logic        ds_rs2_en;
   logic [4:0]  ds_rd;
   logic        ds_we;
   logic        ex_allow_in;
   logic        flush;
   logic        wb_valid;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic        ds_ready_go;
   logic        ds_fire;
   logic [31:0] busy_vec;
   logic [31:0] stall_cnt;

   issue_scoreboard dut (
      .clk         (clk),
      .reset       (reset),
      .ds_valid    (ds_valid),
      .ds_rs1      (ds_rs1),
      .ds_rs1_en   (ds_rs1_en),
      .ds_rs2      (ds_rs2),
      .ds_rs2_en   (ds_rs2_en),
      .ds_rd       (ds_rd),
      .ds_we       (ds_we),
      .ex_allow_in (ex_allow_in),
      .flush       (flush),
      .wb_valid    (wb_valid),
      .wb_we       (wb_we),
      .wb_rd       (wb_rd),
      .ds_ready_go (ds_ready_go),
      .ds_fire     (ds_fire),
      .busy_vec    (busy_vec),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   int          n_pass  = 0;
   int          n_total = 0;
   int          q_rd[$];          // destinations of issued writers, oldest first
   logic [31:0] stall_m = '0;
   logic        wb_pop   = 1'b0;
   logic        wb_noise = 1'b0;
   logic        obs_rdy;
   logic        obs_fire;
   logic [31:0] obs_busy;

   localparam int MAX_PENDING = 3;

   function automatic int mcnt(input int r);
      int c = 0;
      if (r == 0) return 0;
      foreach (q_rd[k]) if (q_rd[k] == r) c++;
      return c;
   endfunction

   function automatic logic [31:0] mbusy();
      logic [31:0] b = '0;
      for (int r = 1; r < 32; r++) b[r] = (mcnt(r) > 0);
      return b;
   endfunction

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      n_total++;
      assert (o === e) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
   endtask

   task automatic set_id(input logic v, input int rs1, input logic e1, input int rs2,
                         input logic e2, input int rd, input logic we, input logic al,
                         input logic fl);
      ds_valid    = v;
      ds_rs1      = 5'(rs1);
      ds_rs1_en   = e1;
      ds_rs2      = 5'(rs2);
      ds_rs2_en   = e2;
      ds_rd       = 5'(rd);
      ds_we       = we;
      ex_allow_in = al;
      flush       = fl;
   endtask

   // One clock cycle: drive WB, check combinational outputs, then advance the model.
   task automatic step(input string tag);
      logic popped;
      logic e_haz;
      logic e_rdy;
      logic e_fire;
      logic [31:0] e_stall;
      popped = 1'b0;
      if (wb_pop && (q_rd.size() > 0)) begin
         wb_valid = 1'b1;
         wb_we    = 1'b1;
         wb_rd    = 5'(q_rd[0]);
         popped   = 1'b1;
      end else if (wb_noise) begin
         wb_valid = 1'b1;
         wb_we    = 1'b0;
         wb_rd    = 5'($urandom);
      end else begin
         wb_valid = 1'b0;
         wb_we    = 1'($urandom);
         wb_rd    = 5'($urandom);
      end
      #2;
      e_haz  = (ds_rs1_en && mcnt(int'(ds_rs1)) > 0) ||
               (ds_rs2_en && mcnt(int'(ds_rs2)) > 0) ||
               (ds_we && mcnt(int'(ds_rd)) == MAX_PENDING);
      e_rdy  = !e_haz && !flush;
      e_fire = ds_valid && e_rdy && ex_allow_in;
`ifdef SB_STATS_EN
      e_stall = stall_m;
`else
      e_stall = '0;
`endif
      obs_rdy  = ds_ready_go;
      obs_fire = ds_fire;
      obs_busy = busy_vec;
      chk({tag, "_ready_go"}, 64'(ds_ready_go), 64'(e_rdy));
      chk({tag, "_fire"},     64'(ds_fire),     64'(e_fire));
      chk({tag, "_busy_vec"}, 64'(busy_vec),    64'(mbusy()));
      chk({tag, "_stall"},    64'(stall_cnt),   64'(e_stall));
      @(posedge clk);
      if (popped) void'(q_rd.pop_front());
      if (e_fire && ds_we) q_rd.push_back(int'(ds_rd));
      if (ds_valid && !flush && e_haz && ex_allow_in) stall_m = stall_m + 32'd1;
      #1;
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      wb_valid = 1'b0;
      wb_we    = 1'b0;
      wb_rd    = '0;
      @(posedge clk);
      #1;
      chk({tag, "_busy_vec"}, 64'(busy_vec),    64'h0);
      chk({tag, "_ready_go"}, 64'(ds_ready_go), 64'h1);
      chk({tag, "_fire"},     64'(ds_fire),     64'h0);
      chk({tag, "_stall"},    64'(stall_cnt),   64'h0);
      reset = 1'b0;
      q_rd.delete();
      stall_m = '0;
   endtask

   task automatic drain();
      set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      wb_pop = 1'b1;
      for (int i = 0; i < 8 && q_rd.size() > 0; i++) step("drain");
      wb_pop = 1'b0;
      step("idle");
      chk("drain_empty", 64'(busy_vec), 64'h0);
   endtask

   initial begin
      reset = 1'b1;
      set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      wb_valid = 1'b0;
      wb_we    = 1'b0;
      wb_rd    = '0;
      @(posedge clk);
      do_reset("reset");

      // RAW on x5: reader waits until the cycle after the producer's WB.
      set_id(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0);
      step("t1_prod");
      chk("t1_prod_fire", 64'(obs_fire), 64'h1);
      set_id(1'b1, 5, 1'b1, 0, 1'b0, 6, 1'b0, 1'b1, 1'b0);
      step("t1_wait0");
      step("t1_wait1");
      chk("t1_stalled", 64'(obs_rdy), 64'h0);
      wb_pop = 1'b1;
      step("t1_wbcyc");
      chk("t1_no_bypass", 64'(obs_rdy), 64'h0);
      wb_pop = 1'b0;
      step("t1_go");
      chk("t1_issued", 64'(obs_fire), 64'h1);

      // x0 writers and readers are invisible to the scoreboard.
      set_id(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
      repeat (3) step("t2_wr_x0");
      set_id(1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
      step("t2_rd_x0");
      chk("t2_no_stall", 64'(obs_fire), 64'h1);
      chk("t2_busy_zero", 64'(obs_busy), 64'h0);
      drain();

      // Issue to x7 in the same cycle as x7's writeback: count stays 1.
      set_id(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b1, 1'b0);
      step("t3_first");
      wb_pop = 1'b1;
      step("t3_simul");
      chk("t3_simul_fire", 64'(obs_fire), 64'h1);
      wb_pop = 1'b0;
      set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      step("t3_after");
      chk("t3_busy7", 64'(obs_busy[7]), 64'h1);
      drain();

      // Three writers to x9 saturate the counter; the fourth waits for one WB.
      set_id(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b1, 1'b0);
      repeat (3) step("t4_fill");
      step("t4_full");
      chk("t4_sat_block", 64'(obs_rdy), 64'h0);
      wb_pop = 1'b1;
      step("t4_wbcyc");
      wb_pop = 1'b0;
      step("t4_go");
      chk("t4_issued", 64'(obs_fire), 64'h1);
      drain();

      // Flush squashes an otherwise issuable instruction.
      set_id(1'b1, 0, 1'b0, 0, 1'b0, 12, 1'b1, 1'b1, 1'b1);
      step("t5_flush");
      chk("t5_no_fire", 64'(obs_fire), 64'h0);
      set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      step("t5_after");
      chk("t5_busy12", 64'(obs_busy[12]), 64'h0);

      // Two writers to x3, a stalled reader, then reset mid-run.
      set_id(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b1, 1'b0);
      repeat (2) step("t6_fill");
      set_id(1'b1, 0, 1'b0, 3, 1'b1, 4, 1'b1, 1'b1, 1'b0);
      repeat (2) step("t6_stall");
      set_id(1'b1, 0, 1'b0, 3, 1'b1, 4, 1'b1, 1'b0, 1'b0);
      step("t6_backpr");
      chk("t6_busy3", 64'(obs_busy[3]), 64'h1);
      do_reset("t6_reset");

      // Randomized traffic concentrated on a few registers to provoke hazards.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset("rnd_reset");
         end else begin
            set_id(1'($urandom_range(0, 3) != 0),
                   int'($urandom_range(0, 7)), 1'($urandom),
                   int'($urandom_range(0, 7)), 1'($urandom),
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                               : int'($urandom_range(0, 7)),
                   1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 4) != 0),
                   1'($urandom_range(0, 9) == 0));
            wb_pop   = 1'($urandom_range(0, 99) < 35);
            wb_noise = 1'($urandom_range(0, 9) == 0);
            step("rnd");
         end
      end
      wb_noise = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
